// File: rtl/lsu_ctrl_pkg.sv
// Data-memory access type codes shared with the data memory, plus small
// helpers used by the load/store sequencer.
package lsu_ctrl_pkg;

   localparam logic [2:0] DM_WORD              = 3'b000;
   localparam logic [2:0] DM_HALFWORD          = 3'b001;
   localparam logic [2:0] DM_HALFWORD_UNSIGNED = 3'b010;
   localparam logic [2:0] DM_BYTE              = 3'b011;
   localparam logic [2:0] DM_BYTE_UNSIGNED     = 3'b100;

   // Codes 5..7 are undefined and behave as a full word.
   function automatic logic [2:0] dm_norm(input logic [2:0] t);
      return (t > DM_BYTE_UNSIGNED) ? DM_WORD : t;
   endfunction

   function automatic logic dm_misaligned(input logic [2:0] t, input logic [1:0] off);
      case (t)
         DM_WORD:                           return off != 2'b00;
         DM_HALFWORD, DM_HALFWORD_UNSIGNED: return off[0];
         default:                           return 1'b0;
      endcase
   endfunction

   function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
      case (i)
         2'd0:    return w[7:0];
         2'd1:    return w[15:8];
         2'd2:    return w[23:16];
         default: return w[31:24];
      endcase
   endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load result lane select and sign/zero extension.
module lsu_load_ext
   import lsu_ctrl_pkg::*;
(
   input  logic [31:0] raw,
   input  logic [2:0]  dm_type,
   input  logic [1:0]  offset,
   output logic [31:0] ext
);

   logic [31:0] lane;

   assign lane = raw >> {offset, 3'b000};

   always_comb begin
      ext = lane;
      case (dm_type)
         DM_BYTE:              ext = {{24{lane[7]}}, lane[7:0]};
         DM_BYTE_UNSIGNED:     ext = {24'h000000, lane[7:0]};
         DM_HALFWORD:          ext = {{16{lane[15]}}, lane[15:0]};
         DM_HALFWORD_UNSIGNED: ext = {16'h0000, lane[15:0]};
         default:              ext = lane;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// MEM-stage load/store sequencer: one request at a time, misaligned accesses
// optionally split into byte beats, sign extension done locally.
module lsu_ctrl
   import lsu_ctrl_pkg::*;
#(
   parameter int unsigned SPLIT_MISALIGNED = 1
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wr,
   input  logic [2:0]  req_type,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_misaligned,
   output logic        DMWr,
   output logic [2:0]  DMType,
   output logic [31:0] addr,
   output logic [31:0] din,
   input  logic [31:0] dout
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t      state;
   logic        wr_q, split_q;
   logic [2:0]  type_q;
   logic [31:0] addr_q, wdata_q, raw_q, raw_next, ext_data;
   logic [1:0]  beat_q, last_q, nxt_beat, acc_last;
   logic [2:0]  acc_type;
   logic        acc_mis;
   logic [7:0]  lane_byte;
   logic [31:0] nxt_addr;

   assign acc_type  = dm_norm(req_type);
   assign acc_mis   = dm_misaligned(acc_type, req_addr[1:0]);
   assign acc_last  = !acc_mis ? 2'd0 : ((acc_type == DM_WORD) ? 2'd3 : 2'd1);
   assign nxt_beat  = beat_q + 2'd1;
   assign nxt_addr  = addr_q + {30'b0, nxt_beat};
   // Memory returns the addressed byte in its own lane, not at bit 0.
   assign lane_byte = byte_sel(dout, addr[1:0]);

   always_comb begin
      raw_next = raw_q;
      if (split_q) begin
         case (beat_q)
            2'd0:    raw_next[7:0]   = lane_byte;
            2'd1:    raw_next[15:8]  = lane_byte;
            2'd2:    raw_next[23:16] = lane_byte;
            default: raw_next[31:24] = lane_byte;
         endcase
      end else begin
         raw_next = dout;
      end
   end

   lsu_load_ext u_ext (
      .raw     (raw_next),
      .dm_type (type_q),
      .offset  (split_q ? 2'b00 : addr_q[1:0]),
      .ext     (ext_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         req_ready       <= 1'b1;
         resp_valid      <= 1'b0;
         resp_rdata      <= '0;
         resp_misaligned <= 1'b0;
         DMWr            <= 1'b0;
         DMType          <= DM_WORD;
         addr            <= '0;
         din             <= '0;
         wr_q            <= 1'b0;
         type_q          <= DM_WORD;
         addr_q          <= '0;
         wdata_q         <= '0;
         raw_q           <= '0;
         beat_q          <= '0;
         last_q          <= '0;
         split_q         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  wr_q      <= req_wr;
                  type_q    <= acc_type;
                  addr_q    <= req_addr;
                  wdata_q   <= req_wdata;
                  raw_q     <= '0;
                  beat_q    <= '0;
                  last_q    <= acc_last;
                  split_q   <= acc_mis;
                  req_ready <= 1'b0;
                  if (acc_mis && SPLIT_MISALIGNED == 0) begin
                     state           <= RESP;
                     resp_valid      <= 1'b1;
                     resp_misaligned <= 1'b1;
                     resp_rdata      <= '0;
                  end else begin
                     state <= ACCESS;
                     addr  <= req_addr;
                     DMWr  <= req_wr;
                     if (acc_mis) begin
                        DMType <= req_wr ? DM_BYTE : DM_BYTE_UNSIGNED;
                        din    <= req_wr ? {24'h000000, req_wdata[7:0]} : '0;
                     end else begin
                        DMType <= acc_type;
                        din    <= req_wdata;
                     end
                  end
               end
            end
            ACCESS: begin
               raw_q <= raw_next;
               if (beat_q == last_q) begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_rdata <= wr_q ? '0 : ext_data;
                  DMWr       <= 1'b0;
                  DMType     <= DM_WORD;
                  addr       <= '0;
                  din        <= '0;
               end else begin
                  beat_q <= nxt_beat;
                  addr   <= nxt_addr;
                  din    <= wr_q ? {24'h000000, byte_sel(wdata_q, nxt_beat)} : '0;
               end
            end
            RESP: begin
               state           <= IDLE;
               resp_valid      <= 1'b0;
               resp_misaligned <= 1'b0;
               resp_rdata      <= '0;
               req_ready       <= 1'b1;
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a byte-array data memory model and a
// second instance built with splitting disabled.
module tb_lsu_ctrl;
   import lsu_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_wr;
   logic [2:0]  req_type;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_misaligned;
   logic [31:0] resp_rdata;
   logic        DMWr;
   logic [2:0]  DMType;
   logic [31:0] addr, din, dout;

   logic        v2, ready2, wr2, rv2, rm2, dmwr2;
   logic [2:0]  ty2, dmtype2;
   logic [31:0] a2, wd2, rd2, addr2, din2;

   logic [7:0]  mem [256];
   logic        mem_clr;
   logic [31:0] w;

   int          n_cmp = 0;
   int          n_err = 0;

   int          nwr;
   logic [31:0] wa [8];
   logic [31:0] wd [8];
   logic [2:0]  wt [8];
   int          wc [8];

   always #5 clk = ~clk;

   lsu_ctrl #(.SPLIT_MISALIGNED(1)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_wr(req_wr), .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_misaligned(resp_misaligned),
      .DMWr(DMWr), .DMType(DMType), .addr(addr), .din(din), .dout(dout)
   );

   lsu_ctrl #(.SPLIT_MISALIGNED(0)) u_nosplit (
      .clk(clk), .rst(rst), .req_valid(v2), .req_ready(ready2),
      .req_wr(wr2), .req_type(ty2), .req_addr(a2), .req_wdata(wd2),
      .resp_valid(rv2), .resp_rdata(rd2), .resp_misaligned(rm2),
      .DMWr(dmwr2), .DMType(dmtype2), .addr(addr2), .din(din2), .dout(32'h0)
   );

   // Stores take right-aligned data; reads return the word with only the
   // accessed lanes populated.
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hA5;
      end else if (DMWr) begin
         case (DMType)
            DM_WORD: for (int b = 0; b < 4; b++) mem[{addr[7:2], 2'(b)}] <= din[8*b +: 8];
            DM_HALFWORD, DM_HALFWORD_UNSIGNED: begin
               mem[addr[7:0]]         <= din[7:0];
               mem[addr[7:0] + 8'd1]  <= din[15:8];
            end
            default: mem[addr[7:0]] <= din[7:0];
         endcase
      end
   end

   always_comb begin
      w = {mem[{addr[7:2], 2'd3}], mem[{addr[7:2], 2'd2}],
           mem[{addr[7:2], 2'd1}], mem[{addr[7:2], 2'd0}]};
      case (DMType)
         DM_WORD:                           dout = w;
         DM_HALFWORD, DM_HALFWORD_UNSIGNED: dout = addr[1] ? {w[31:16], 16'h0} : {16'h0, w[15:0]};
         default:                           dout = w & (32'hFF << {addr[1:0], 3'b000});
      endcase
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic xact(input logic wr, input logic [2:0] ty, input logic [31:0] a,
                       input logic [31:0] wdat, output logic [31:0] rd,
                       output logic mis, output int cyc);
      int guard;
      guard = 0;
      @(negedge clk);
      req_valid = 1'b1; req_wr = wr; req_type = ty; req_addr = a; req_wdata = wdat;
      while (!req_ready && guard < 16) begin
         @(negedge clk);
         guard++;
      end
      check("accept", 32'(req_ready), 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
      cyc = 1;
      nwr = 0;
      while (!resp_valid && cyc < 12) begin
         if (DMWr && nwr < 8) begin
            wa[nwr] = addr; wd[nwr] = din; wt[nwr] = DMType; wc[nwr] = cyc;
            nwr++;
         end
         @(negedge clk);
         cyc++;
      end
      if (DMWr) nwr++;
      check("resp_seen", 32'(resp_valid), 32'd1);
      rd  = resp_rdata;
      mis = resp_misaligned;
   endtask

   initial begin
      logic [31:0] rd;
      logic        mis;
      int          cyc;

      rst = 1'b1; mem_clr = 1'b1;
      req_valid = 1'b0; req_wr = 1'b0; req_type = DM_WORD; req_addr = '0; req_wdata = '0;
      v2 = 1'b0; wr2 = 1'b0; ty2 = DM_WORD; a2 = '0; wd2 = '0;
      @(negedge clk);
      check("rst_ready",  32'(req_ready),  32'd1);
      check("rst_resp",   32'(resp_valid), 32'd0);
      check("rst_dmwr",   32'(DMWr),       32'd0);
      check("rst_addr",   addr,            32'h0);
      check("rst_din",    din,             32'h0);
      check("rst_rdata",  resp_rdata,      32'h0);
      rst = 1'b0; mem_clr = 1'b0;

      // aligned word round trip
      xact(1'b1, DM_WORD, 32'h10, 32'hDEADBEEF, rd, mis, cyc);
      check("sw_nwr",   32'(nwr),    32'd1);
      check("sw_cycle", 32'(wc[0]),  32'd1);
      check("sw_type",  32'(wt[0]),  32'(DM_WORD));
      check("sw_addr",  wa[0],       32'h10);
      check("sw_din",   wd[0],       32'hDEADBEEF);
      check("sw_resp",  32'(cyc),    32'd2);
      check("sw_rdata", rd,          32'h0);
      xact(1'b0, DM_WORD, 32'h10, 32'h0, rd, mis, cyc);
      check("lw_rdata", rd,       32'hDEADBEEF);
      check("lw_resp",  32'(cyc), 32'd2);
      check("lw_mis",   32'(mis), 32'd0);

      // aligned sub-word extension
      xact(1'b1, DM_WORD, 32'h10, 32'h80FF7F01, rd, mis, cyc);
      xact(1'b0, DM_BYTE, 32'h13, 32'h0, rd, mis, cyc);
      check("lb_13", rd, 32'hFFFFFF80);
      xact(1'b0, DM_BYTE_UNSIGNED, 32'h13, 32'h0, rd, mis, cyc);
      check("lbu_13", rd, 32'h00000080);
      xact(1'b0, DM_HALFWORD, 32'h12, 32'h0, rd, mis, cyc);
      check("lh_12", rd, 32'hFFFF80FF);
      xact(1'b0, DM_HALFWORD_UNSIGNED, 32'h12, 32'h0, rd, mis, cyc);
      check("lhu_12", rd, 32'h000080FF);
      xact(1'b0, DM_BYTE, 32'h10, 32'h0, rd, mis, cyc);
      check("lb_10", rd, 32'h00000001);
      xact(1'b0, 3'b111, 32'h10, 32'h0, rd, mis, cyc);
      check("undef_type", rd, 32'h80FF7F01);

      // misaligned word split
      xact(1'b1, DM_WORD, 32'h21, 32'h44332211, rd, mis, cyc);
      check("split_nwr",  32'(nwr), 32'd4);
      check("split_resp", 32'(cyc), 32'd5);
      check("split_a0", wa[0], 32'h21); check("split_d0", wd[0], 32'h11); check("split_c0", 32'(wc[0]), 32'd1);
      check("split_a1", wa[1], 32'h22); check("split_d1", wd[1], 32'h22); check("split_c1", 32'(wc[1]), 32'd2);
      check("split_a2", wa[2], 32'h23); check("split_d2", wd[2], 32'h33); check("split_c2", 32'(wc[2]), 32'd3);
      check("split_a3", wa[3], 32'h24); check("split_d3", wd[3], 32'h44); check("split_c3", 32'(wc[3]), 32'd4);
      check("split_type", 32'(wt[3]), 32'(DM_BYTE));
      check("byte20_kept", 32'(mem[8'h20]), 32'h85);
      xact(1'b0, DM_WORD, 32'h21, 32'h0, rd, mis, cyc);
      check("split_lw",      rd,       32'h44332211);
      check("split_lw_resp", 32'(cyc), 32'd5);

      // misaligned halfword load
      xact(1'b1, DM_BYTE, 32'h23, 32'h80, rd, mis, cyc);
      xact(1'b1, DM_BYTE, 32'h24, 32'hF0, rd, mis, cyc);
      xact(1'b0, DM_HALFWORD, 32'h23, 32'h0, rd, mis, cyc);
      check("lh_23",      rd,       32'hFFFFF080);
      check("lh_23_resp", 32'(cyc), 32'd3);
      xact(1'b0, DM_HALFWORD_UNSIGNED, 32'h23, 32'h0, rd, mis, cyc);
      check("lhu_23", rd, 32'h0000F080);

      // address wrap across the top of memory
      xact(1'b1, DM_HALFWORD, 32'hFFFFFFFF, 32'h1234BEEF, rd, mis, cyc);
      check("wrap_a0", wa[0], 32'hFFFFFFFF); check("wrap_d0", wd[0], 32'hEF);
      check("wrap_a1", wa[1], 32'h00000000); check("wrap_d1", wd[1], 32'hBE);
      xact(1'b0, DM_HALFWORD_UNSIGNED, 32'hFFFFFFFF, 32'h0, rd, mis, cyc);
      check("wrap_lhu", rd, 32'h0000BEEF);

      // splitting disabled: reject, then accept the waiting aligned request
      @(negedge clk);
      check("ns_ready", 32'(ready2), 32'd1);
      v2 = 1'b1; wr2 = 1'b1; ty2 = DM_WORD; a2 = 32'h22; wd2 = 32'hCAFEF00D;
      @(negedge clk);
      check("ns_resp_valid", 32'(rv2),    32'd1);
      check("ns_misaligned", 32'(rm2),    32'd1);
      check("ns_dmwr_c1",    32'(dmwr2),  32'd0);
      check("ns_ready_c1",   32'(ready2), 32'd0);
      a2 = 32'h20;
      @(negedge clk);
      check("ns_resp_clear", 32'(rv2),    32'd0);
      check("ns_dmwr_c2",    32'(dmwr2),  32'd0);
      check("ns_ready_c2",   32'(ready2), 32'd1);
      @(negedge clk);
      v2 = 1'b0;
      check("ns_aligned_wr",   32'(dmwr2), 32'd1);
      check("ns_aligned_addr", addr2,      32'h20);
      repeat (2) @(negedge clk);

      // reset during beat 2 of a split store
      req_valid = 1'b1; req_wr = 1'b1; req_type = DM_WORD;
      req_addr = 32'h41; req_wdata = 32'h5A6B7C8D;
      @(negedge clk);
      req_valid = 1'b0;
      check("rst_beat1_addr", addr, 32'h41);
      @(negedge clk);
      check("rst_beat2_addr", addr, 32'h42);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_dmwr", 32'(DMWr),       32'd0);
      check("rst_mid_resp", 32'(resp_valid), 32'd0);
      rst = 1'b0;
      check("rst_mid_ready", 32'(req_ready), 32'd1);
      repeat (2) @(negedge clk);
      check("rst_mem41", 32'(mem[8'h41]), 32'h8D);
      check("rst_mem42", 32'(mem[8'h42]), 32'h7C);
      check("rst_mem43", 32'(mem[8'h43]), 32'hE6);
      check("rst_mem44", 32'(mem[8'h44]), 32'hE1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
